dram_wr_ctrl: RTL and testbench
===============================

// Module: dram_wr_ctrl
// PURPOSE
//  Store-side data-memory controller: the write counterpart of the write-back load extraction.
//  Accepts a store (B/H/W per ram_op_enum DRAM_WR_* codes) from the EX/MEM stage and emits
//  word-aligned DRAM write beats with per-byte enables, lane-shifted data and a wait-state ack.
//  Misaligned stores crossing a word boundary split into two beats.
// PARAMETERS
//  XLEN      32  data/address width; only 32 is supported (4 byte lanes)
//  SPLIT_EN  1   1: split word-crossing stores into two beats; 0: flag them as errors, no write
// PORTS
//  clk_i          in   1       clock, all state on rising edge
//  rst_n_i        in   1       asynchronous, active-low reset
//  req_valid_i    in   1       store request valid
//  req_ready_o    out  1       controller can accept a request (high only in IDLE)
//  dram_wr_sel_i  in   3       DRAM_WR_B / DRAM_WR_H / DRAM_WR_W; any other code illegal
//  addr_i         in   XLEN    byte address of the store
//  data_i         in   XLEN    store data, right-justified (B in [7:0], H in [15:0])
//  mem_we_o       out  1       write beat valid; held until mem_ack_i
//  mem_addr_o     out  XLEN    word-aligned beat address ([1:0] always 0)
//  mem_be_o       out  XLEN/8  byte enables for the beat
//  mem_data_o     out  XLEN    lane-aligned write data; bytes with be=0 driven 0
//  mem_ack_i      in   1       DRAM accepted current beat (sampled only while mem_we_o=1)
//  done_o         out  1       one-cycle pulse: store fully written
//  err_o          out  1       one-cycle pulse: request rejected (illegal sel / misaligned, SPLIT_EN=0)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready_o=1; mem_we_o/done_o/err_o=0; mem_addr_o/mem_be_o/mem_data_o=0.
//  Reset is async: mid-store assertion drops mem_we_o immediately; the in-flight store is lost.
//  States: IDLE -> BEAT0 -> [BEAT1] -> IDLE.
//  IDLE: on req_valid_i&req_ready_o capture sel/addr/data; later input changes are ignored.
//   Illegal sel, or crossing with SPLIT_EN=0: stay IDLE, err_o=1 next cycle, no beat issued.
//   Otherwise -> BEAT0; mem_we_o rises the cycle after acceptance.
//  Lane math: off=addr[1:0]; base mask B=4'b0001 H=4'b0011 W=4'b1111;
//   be8 = {4'b0,mask} << off; d64 = {32'b0,data} << (8*off) (data masked to size first).
//   crossing = |be8[7:4].
//  BEAT0: mem_addr_o={addr[XLEN-1:2],2'b00}, mem_be_o=be8[3:0], mem_data_o=d64[31:0].
//   On mem_ack_i: crossing -> BEAT1, else -> IDLE with done_o=1 next cycle.
//  BEAT1: mem_addr_o=BEAT0 addr + 4 (mod 2^XLEN), mem_be_o=be8[7:4], mem_data_o=d64[63:32].
//   On mem_ack_i -> IDLE, done_o=1 next cycle.
//  Beat outputs are registered and stable while mem_we_o=1 and ack is low (unbounded wait).
//  mem_we_o deasserts the cycle after the final ack. done_o and req_ready_o are both high in
//   that cycle, so a new request can be accepted there (back-to-back throughput: 1 store / 2 cycles min).
//  Min latency, aligned store, zero-wait ack: accept N, beat N+1, done_o N+2.
//  done_o and err_o are never both high. mem_ack_i outside a beat is ignored.
// TESTING
//  1 SW addr 0x100 data 0xDEADBEEF, ack immediate -> one beat 0x100 be 1111 data 0xDEADBEEF;
//    done_o exactly 2 cycles after accept.
//  2 SB addr 0x103 data 0x123456A5 -> one beat 0x100 be 1000 data 0xA5000000.
//  3 SH addr 0x203 data 0x00001234 -> beat0 0x200 be 1000 data 0x34000000;
//    beat1 0x204 be 0001 data 0x00000012; one done_o.
//  4 SW addr 0xFFFFFFFE data 0xDEADBEEF, ack delayed 3 cycles per beat ->
//    beat0 0xFFFFFFFC be 1100 data 0xBEEF0000, held 3 cycles;
//    beat1 0x00000000 be 0011 data 0x0000DEAD.
//  5 sel 3'b111 -> err_o pulse, mem_we_o never high. SPLIT_EN=0 with SW addr 0x101 -> err_o, no beat.
//    Next aligned SW completes normally.
//  6 rst_n_i low during stalled BEAT1 -> mem_we_o=0 same cycle; after release req_ready_o=1;
//    new SB completes; back-to-back SW pair accepted on done_o cycle.

Source files
------------

// File: rtl/dram_wr_ctrl.sv
// Store-side DRAM write controller: turns B/H/W stores into word-aligned write beats
// with byte enables, splitting word-crossing stores into two beats when SPLIT_EN=1.
module dram_wr_ctrl #(
   parameter int XLEN     = 32,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        dram_wr_sel_i,
   input  logic [XLEN-1:0]   addr_i,
   input  logic [XLEN-1:0]   data_i,
   output logic              mem_we_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_data_o,
   input  logic              mem_ack_i,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [2:0] DRAM_WR_B = 3'd0;
   localparam logic [2:0] DRAM_WR_H = 3'd1;
   localparam logic [2:0] DRAM_WR_W = 3'd2;

   typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1} state_t;

   state_t            r_state;
   logic              r_cross;
   logic [3:0]        r_be_hi;
   logic [XLEN-1:0]   r_data_hi;

   logic              w_legal;
   logic [3:0]        w_mask;
   logic [XLEN-1:0]   w_dmask;
   logic [1:0]        w_off;
   logic [7:0]        w_be8;
   logic [2*XLEN-1:0] w_d64;
   logic              w_cross;

   always_comb begin
      w_legal = 1'b1;
      w_mask  = 4'b0000;
      w_dmask = '0;
      case (dram_wr_sel_i)
         DRAM_WR_B: begin
            w_mask  = 4'b0001;
            w_dmask = {{(XLEN-8){1'b0}}, data_i[7:0]};
         end
         DRAM_WR_H: begin
            w_mask  = 4'b0011;
            w_dmask = {{(XLEN-16){1'b0}}, data_i[15:0]};
         end
         DRAM_WR_W: begin
            w_mask  = 4'b1111;
            w_dmask = data_i;
         end
         default: w_legal = 1'b0;
      endcase
   end

   // Lane placement over a two-word window; the upper word is the second beat.
   assign w_off   = addr_i[1:0];
   assign w_be8   = {4'b0000, w_mask} << w_off;
   assign w_d64   = {{XLEN{1'b0}}, w_dmask} << {w_off, 3'b000};
   assign w_cross = |w_be8[7:4];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= S_IDLE;
         r_cross     <= 1'b0;
         r_be_hi     <= 4'b0000;
         r_data_hi   <= '0;
         req_ready_o <= 1'b1;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_data_o  <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  if (!w_legal || (w_cross && !SPLIT_EN)) begin
                     err_o <= 1'b1;
                  end else begin
                     r_state     <= S_BEAT0;
                     req_ready_o <= 1'b0;
                     mem_we_o    <= 1'b1;
                     mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                     mem_be_o    <= w_be8[3:0];
                     mem_data_o  <= w_d64[XLEN-1:0];
                     r_cross     <= w_cross;
                     r_be_hi     <= w_be8[7:4];
                     r_data_hi   <= w_d64[2*XLEN-1:XLEN];
                  end
               end
            end
            S_BEAT0: begin
               if (mem_ack_i) begin
                  if (r_cross) begin
                     r_state    <= S_BEAT1;
                     mem_addr_o <= mem_addr_o + XLEN'(4);
                     mem_be_o   <= r_be_hi;
                     mem_data_o <= r_data_hi;
                  end else begin
                     r_state     <= S_IDLE;
                     mem_we_o    <= 1'b0;
                     req_ready_o <= 1'b1;
                     done_o      <= 1'b1;
                  end
               end
            end
            S_BEAT1: begin
               if (mem_ack_i) begin
                  r_state     <= S_IDLE;
                  mem_we_o    <= 1'b0;
                  req_ready_o <= 1'b1;
                  done_o      <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_wr_ctrl.sv
// Scoreboard bench for dram_wr_ctrl: directed stores push expected beats/done/err events,
// a negedge monitor pops and compares them and also acts as the DRAM ack responder.
module tb_dram_wr_ctrl;

   localparam logic [2:0] SB = 3'd0;
   localparam logic [2:0] SH = 3'd1;
   localparam logic [2:0] SW = 3'd2;

   localparam int K_BEAT = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  sel = 3'd0;
   logic [31:0] addr = '0;
   logic [31:0] data = '0;
   logic        ack = 1'b0;
   bit          use_ns = 1'b0;

   logic        a_ready, a_we, a_done, a_err;
   logic [31:0] a_addr, a_data;
   logic [3:0]  a_be;
   logic        n_ready, n_we, n_done, n_err;
   logic [31:0] n_addr, n_data;
   logic [3:0]  n_be;

   logic        m_ready, m_we, m_done, m_err;
   logic [31:0] m_addr, m_data;
   logic [3:0]  m_be;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ack_wait = 0;
   bit   stall_en = 1'b0;
   logic [31:0] stall_addr = '0;

   dram_wr_ctrl #(.XLEN(32), .SPLIT_EN(1'b1)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid & ~use_ns), .req_ready_o(a_ready),
      .dram_wr_sel_i(sel), .addr_i(addr), .data_i(data),
      .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_be_o(a_be), .mem_data_o(a_data),
      .mem_ack_i(ack), .done_o(a_done), .err_o(a_err)
   );

   dram_wr_ctrl #(.XLEN(32), .SPLIT_EN(1'b0)) u_dut_ns (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid & use_ns), .req_ready_o(n_ready),
      .dram_wr_sel_i(sel), .addr_i(addr), .data_i(data),
      .mem_we_o(n_we), .mem_addr_o(n_addr), .mem_be_o(n_be), .mem_data_o(n_data),
      .mem_ack_i(ack), .done_o(n_done), .err_o(n_err)
   );

   assign m_ready = use_ns ? n_ready : a_ready;
   assign m_we    = use_ns ? n_we    : a_we;
   assign m_addr  = use_ns ? n_addr  : a_addr;
   assign m_be    = use_ns ? n_be    : a_be;
   assign m_data  = use_ns ? n_data  : a_data;
   assign m_done  = use_ns ? n_done  : a_done;
   assign m_err   = use_ns ? n_err   : a_err;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int k, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input int c);
      exp_t e;
      e.kind = k; e.addr = a; e.be = b; e.data = d; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic observe(input int k, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d);
      exp_t e;
      bit   bad;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d addr %h be %b data %h, expected none",
                  k, a, b, d);
      end else begin
         e = q.pop_front();
         bad = (e.kind != k);
         if (k == K_BEAT) bad = bad || (a !== e.addr) || (b !== e.be) || (d !== e.data);
         if (e.cyc >= 0) bad = bad || (cyc != e.cyc);
         if (bad) begin
            errors++;
            $display("FAIL event: got kind %0d addr %h be %b data %h cyc %0d, expected kind %0d addr %h be %b data %h cyc %0d",
                     k, a, b, d, cyc, e.kind, e.addr, e.be, e.data, e.cyc);
         end
      end
   endtask

   // Monitor and DRAM ack responder share the falling edge so their ordering is fixed.
   initial begin : monitor
      logic        p_we, p_ack;
      logic [31:0] p_addr, p_data;
      logic [3:0]  p_be;
      int          wcnt;
      p_we = 1'b0; p_ack = 1'b0; p_addr = '0; p_data = '0; p_be = '0; wcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_we = 1'b0; p_ack = 1'b0; ack = 1'b0; wcnt = 0;
         end else begin
            if (m_we && (!p_we || p_ack)) begin
               observe(K_BEAT, m_addr, m_be, m_data);
            end else if (m_we) begin
               chk("hold_addr", m_addr, p_addr);
               chk("hold_be", {28'b0, m_be}, {28'b0, p_be});
               chk("hold_data", m_data, p_data);
            end
            if (m_done) observe(K_DONE, '0, '0, '0);
            if (m_err)  observe(K_ERR, '0, '0, '0);
            if (m_done && m_err) chk("done_err_excl", 32'd1, 32'd0);
            p_we = m_we; p_addr = m_addr; p_be = m_be; p_data = m_data;
            if (m_we && !(stall_en && m_addr == stall_addr) && wcnt >= ack_wait) begin
               ack = 1'b1; wcnt = 0;
            end else if (m_we) begin
               ack = 1'b0; wcnt++;
            end else begin
               ack = 1'b0; wcnt = 0;
            end
            p_ack = ack;
         end
      end
   end

   task automatic issue(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d,
                        output int acc);
      int n;
      n = 0;
      @(negedge clk);
      while (!m_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL ready_timeout: req_ready_o low for %0d cycles, expected high", n);
      end
      sel = s; addr = a; data = d; req_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drain_queue_empty", q.size(), 32'd0);
   endtask

   task automatic chk_reset_state(input string nm);
      chk({nm, "_ready"}, {31'b0, m_ready}, 32'd1);
      chk({nm, "_we"},    {31'b0, m_we},    32'd0);
      chk({nm, "_addr"},  m_addr,           32'd0);
      chk({nm, "_be"},    {28'b0, m_be},    32'd0);
      chk({nm, "_data"},  m_data,           32'd0);
      chk({nm, "_flags"}, {30'b0, m_done, m_err}, 32'd0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int acc, acc2;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      use_ns = 1'b1;
      chk_reset_state("reset_ns");
      use_ns = 1'b0;
      rst_n = 1'b1;

      // Aligned word, zero-wait: done two cycles after acceptance.
      push(K_BEAT, 32'h100, 4'b1111, 32'hDEADBEEF, -1);
      issue(SW, 32'h100, 32'hDEADBEEF, acc);
      push(K_DONE, '0, '0, '0, acc + 1);
      drain();

      push(K_BEAT, 32'h100, 4'b1000, 32'hA500_0000, -1);
      issue(SB, 32'h103, 32'h1234_56A5, acc);
      push(K_DONE, '0, '0, '0, -1);
      drain();

      push(K_BEAT, 32'h100, 4'b1100, 32'h1234_0000, -1);
      issue(SH, 32'h102, 32'hABCD_1234, acc);
      push(K_DONE, '0, '0, '0, -1);
      drain();

      // Halfword crossing a word boundary.
      push(K_BEAT, 32'h200, 4'b1000, 32'h3400_0000, -1);
      push(K_BEAT, 32'h204, 4'b0001, 32'h0000_0012, -1);
      issue(SH, 32'h203, 32'h0000_1234, acc);
      push(K_DONE, '0, '0, '0, -1);
      drain();

      // Word crossing the top of the address space with wait states.
      ack_wait = 3;
      push(K_BEAT, 32'hFFFF_FFFC, 4'b1100, 32'hBEEF_0000, -1);
      push(K_BEAT, 32'h0000_0000, 4'b0011, 32'h0000_DEAD, -1);
      issue(SW, 32'hFFFF_FFFE, 32'hDEADBEEF, acc);
      push(K_DONE, '0, '0, '0, -1);
      drain();
      ack_wait = 0;

      // Rejected requests.
      issue(3'b111, 32'h100, 32'h1111_1111, acc);
      push(K_ERR, '0, '0, '0, acc);
      drain();
      use_ns = 1'b1;
      issue(SW, 32'h101, 32'h2222_2222, acc);
      push(K_ERR, '0, '0, '0, acc);
      drain();
      push(K_BEAT, 32'h000, 4'b0110, 32'h0012_3400, -1);
      issue(SH, 32'h001, 32'h0000_1234, acc);
      push(K_DONE, '0, '0, '0, -1);
      drain();
      push(K_BEAT, 32'h300, 4'b1111, 32'hCAFE_F00D, -1);
      issue(SW, 32'h300, 32'hCAFE_F00D, acc);
      push(K_DONE, '0, '0, '0, acc + 1);
      drain();
      use_ns = 1'b0;

      // Async reset while the second beat is stalled.
      stall_en = 1'b1;
      stall_addr = 32'h204;
      push(K_BEAT, 32'h200, 4'b1000, 32'h3400_0000, -1);
      push(K_BEAT, 32'h204, 4'b0001, 32'h0000_0012, -1);
      issue(SH, 32'h203, 32'h0000_1234, acc);
      begin
         int n;
         n = 0;
         while (!(m_we && m_addr == 32'h204) && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("stall_beat1_reached", {31'b0, m_we}, 32'd1);
      end
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_we", {31'b0, m_we}, 32'd0);
      chk("lost_store_queue", q.size(), 32'd0);
      @(negedge clk);
      chk_reset_state("midreset");
      stall_en = 1'b0;
      rst_n = 1'b1;

      push(K_BEAT, 32'h000, 4'b0010, 32'h0000_7700, -1);
      issue(SB, 32'h001, 32'h0000_0077, acc);
      push(K_DONE, '0, '0, '0, -1);
      drain();

      // Back-to-back words: second accepted on the first one's done cycle.
      push(K_BEAT, 32'h400, 4'b1111, 32'h1111_2222, -1);
      issue(SW, 32'h400, 32'h1111_2222, acc);
      push(K_DONE, '0, '0, '0, acc + 1);
      push(K_BEAT, 32'h404, 4'b1111, 32'h3333_4444, -1);
      issue(SW, 32'h404, 32'h3333_4444, acc2);
      push(K_DONE, '0, '0, '0, acc2 + 1);
      chk("b2b_accept_gap", acc2 - acc, 32'd2);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
